mme_ctrl: RTL and testbench



---
 rtl/mme_pkg.sv | 30 +++
 rtl/mme_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mme_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mme_pkg.sv
// Shared types and constants for the matrix-multiply engine sequencing controller.
package mme_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_A      = 3'd1,
    S_RD_B      = 3'd2,
    S_RD_WAIT   = 3'd3,
    S_COMP      = 3'd4,
    S_COMP_WAIT = 3'd5,
    S_WR        = 3'd6,
    S_WR_WAIT   = 3'd7
  } mme_ctrl_state_t;

  localparam int TILE      = 4;
  localparam int BLK_WORDS = TILE * TILE;
  localparam int BLK_BYTES = BLK_WORDS * 4;
  localparam int BLK_SHIFT = $clog2(BLK_BYTES);
  localparam logic [7:0] BURST_LEN = 8'd15;

  // APB register map of the engine
  localparam logic [11:0] REG_MME_CMD    = 12'h100;
  localparam logic [11:0] REG_MAT_CFG    = 12'h200;
  localparam logic [11:0] REG_MAT_A_ADDR = 12'h204;
  localparam logic [11:0] REG_MAT_B_ADDR = 12'h208;
  localparam logic [11:0] REG_MAT_C_ADDR = 12'h20C;
  localparam logic [11:0] REG_MME_STATUS = 12'h210;
  localparam logic [11:0] REG_MME_PERF   = 12'h214;

endpackage

// File: rtl/mme_ctrl.sv
// Chunked A(4xW)*B(Wx4) job sequencer: block reads, MAC trigger, single C write.
// Optional cycle counter output enabled with `define MME_PERF_CNT_EN.
//
// state       | meaning
// IDLE        | waiting for start; config latched on start
// RD_A        | presenting read request for A block of current chunk
// RD_B        | presenting read request for B block of current chunk
// RD_WAIT     | waiting until both blocks have landed
// COMP        | one-cycle array start (clear on chunk 0)
// COMP_WAIT   | waiting for array to finish the chunk
// WR          | presenting 16-word write request for C
// WR_WAIT     | waiting for final write response
module mme_ctrl
  import mme_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int WIDTH_W   = 8,
  parameter int MAX_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [WIDTH_W-1:0] mat_width_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [ADDR_W-1:0] rd_req_addr_o,
  output logic [7:0]        rd_req_len_o,
  output logic              rd_req_sel_o,
  input  logic              rd_done_i,
  output logic              arr_start_o,
  output logic              arr_clr_o,
  input  logic              arr_done_i,
  output logic              wr_req_valid_o,
  input  logic              wr_req_ready_i,
  output logic [ADDR_W-1:0] wr_req_addr_o,
  output logic [7:0]        wr_req_len_o,
  input  logic              wr_done_i
`ifdef MME_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt_o
`endif
);

  localparam int CW = WIDTH_W - 2;
  localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_WIDTH);

  mme_ctrl_state_t   state_q, state_d;
  logic [CW-1:0]     chunk_q, chunk_d, nchunk_q, nchunk_d;
  logic [1:0]        rd_cnt_q, rd_cnt_d, rd_cnt_inc;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic              done_q, done_d, err_q, err_d;
  logic              width_ok;
  logic [ADDR_W-1:0] chunk_off;

  assign width_ok   = (mat_width_i != '0) && (mat_width_i[1:0] == 2'b00) && (mat_width_i <= MAX_W);
  assign rd_cnt_inc = rd_cnt_q + {1'b0, rd_done_i};
  assign chunk_off  = {{(ADDR_W-CW){1'b0}}, chunk_q} << BLK_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      chunk_q  <= '0;
      nchunk_q <= '0;
      rd_cnt_q <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      nchunk_q <= nchunk_d;
      rd_cnt_q <= rd_cnt_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    nchunk_d = nchunk_q;
    rd_cnt_d = rd_cnt_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_base_d = a_addr_i;
          b_base_d = b_addr_i;
          c_base_d = c_addr_i;
          chunk_d  = '0;
          nchunk_d = mat_width_i[WIDTH_W-1:2];
          rd_cnt_d = '0;
          done_d   = !width_ok;
          err_d    = !width_ok;
          if (width_ok) state_d = S_RD_A;
        end
      end
      // rd_done pulses may land while the second request is still pending
      S_RD_A: begin
        rd_cnt_d = rd_cnt_inc;
        if (rd_req_ready_i) state_d = S_RD_B;
      end
      S_RD_B: begin
        rd_cnt_d = rd_cnt_inc;
        if (rd_req_ready_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_cnt_inc == 2'd2) begin
          rd_cnt_d = '0;
          state_d  = S_COMP;
        end else begin
          rd_cnt_d = rd_cnt_inc;
        end
      end
      S_COMP: state_d = S_COMP_WAIT;
      S_COMP_WAIT: begin
        if (arr_done_i) begin
          chunk_d = chunk_q + CW'(1);
          state_d = (chunk_q + CW'(1) == nchunk_q) ? S_WR : S_RD_A;
        end
      end
      S_WR: if (wr_req_ready_i) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (wr_done_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_req_valid_o = 1'b0;
    rd_req_addr_o  = '0;
    rd_req_len_o   = '0;
    rd_req_sel_o   = 1'b0;
    arr_start_o    = 1'b0;
    arr_clr_o      = 1'b0;
    wr_req_valid_o = 1'b0;
    wr_req_addr_o  = '0;
    wr_req_len_o   = '0;
    unique case (state_q)
      S_RD_A: begin
        rd_req_valid_o = 1'b1;
        rd_req_addr_o  = a_base_q + chunk_off;
        rd_req_len_o   = BURST_LEN;
      end
      S_RD_B: begin
        rd_req_valid_o = 1'b1;
        rd_req_addr_o  = b_base_q + chunk_off;
        rd_req_len_o   = BURST_LEN;
        rd_req_sel_o   = 1'b1;
      end
      S_COMP: begin
        arr_start_o = 1'b1;
        arr_clr_o   = (chunk_q == '0);
      end
      S_WR: begin
        wr_req_valid_o = 1'b1;
        wr_req_addr_o  = c_base_q;
        wr_req_len_o   = BURST_LEN;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

`ifdef MME_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      cycle_cnt_q <= '0;
    end else if (busy_o && cycle_cnt_q != 32'hFFFF_FFFF) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mme_ctrl.sv
// Directed bench for mme_ctrl with a behavioural DMA/array responder.
module tb_mme_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  mat_width_i = '0;
  logic [31:0] a_addr_i = '0, b_addr_i = '0, c_addr_i = '0;
  logic        busy_o, done_o, err_o;
  logic        rd_req_valid_o, rd_req_sel_o;
  logic        rd_req_ready_i = 1'b1;
  logic [31:0] rd_req_addr_o, wr_req_addr_o;
  logic [7:0]  rd_req_len_o, wr_req_len_o;
  logic        rd_done_i = 1'b0, arr_done_i = 1'b0, wr_done_i = 1'b0;
  logic        arr_start_o, arr_clr_o, wr_req_valid_o;
  logic        wr_req_ready_i = 1'b1;
`ifdef MME_PERF_CNT_EN
  logic [31:0] cycle_cnt_o;
`endif

  mme_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mat_width_i(mat_width_i),
    .a_addr_i(a_addr_i), .b_addr_i(b_addr_i), .c_addr_i(c_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i),
    .rd_req_addr_o(rd_req_addr_o), .rd_req_len_o(rd_req_len_o),
    .rd_req_sel_o(rd_req_sel_o), .rd_done_i(rd_done_i),
    .arr_start_o(arr_start_o), .arr_clr_o(arr_clr_o), .arr_done_i(arr_done_i),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
    .wr_req_addr_o(wr_req_addr_o), .wr_req_len_o(wr_req_len_o),
    .wr_done_i(wr_done_i)
`ifdef MME_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // responder knobs and scheduled completion pulses
  int cyc = 0;
  int rd_lat = 1, arr_lat = 1, wr_lat = 1, rd_stall = 0, stall_cnt = 0;
  int rd_due[$], arr_due[$], wr_due[$];

  logic [31:0] rd_addr_log[$], wr_addr_log[$];
  logic        rd_sel_log[$], arr_clr_log[$];
  logic [7:0]  rd_len_log[$], wr_len_log[$];
  int          rd_vld_cyc = 0, wr_vld_cyc = 0;

  logic        prev_pend = 1'b0, prev_sel = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    rd_done_i = (rd_due.size() > 0) && (rd_due[0] <= cyc);
    if (rd_done_i) void'(rd_due.pop_front());
    arr_done_i = (arr_due.size() > 0) && (arr_due[0] <= cyc);
    if (arr_done_i) void'(arr_due.pop_front());
    wr_done_i = (wr_due.size() > 0) && (wr_due[0] <= cyc);
    if (wr_done_i) void'(wr_due.pop_front());
    if (rd_req_valid_o && stall_cnt < rd_stall) begin
      rd_req_ready_i = 1'b0;
      stall_cnt++;
    end else begin
      rd_req_ready_i = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend)
        chk("rd_stable", {rd_req_valid_o, rd_req_sel_o, rd_req_len_o, rd_req_addr_o},
            {1'b1, prev_sel, 8'd15, prev_addr});
      prev_pend = rd_req_valid_o && !rd_req_ready_i;
      prev_sel  = rd_req_sel_o;
      prev_addr = rd_req_addr_o;
      if (rd_req_valid_o) rd_vld_cyc++;
      if (rd_req_valid_o && rd_req_ready_i) begin
        rd_addr_log.push_back(rd_req_addr_o);
        rd_sel_log.push_back(rd_req_sel_o);
        rd_len_log.push_back(rd_req_len_o);
        rd_due.push_back(cyc + rd_lat);
        stall_cnt = 0;
      end
      if (arr_start_o) begin
        arr_clr_log.push_back(arr_clr_o);
        arr_due.push_back(cyc + arr_lat);
      end
      if (wr_req_valid_o) wr_vld_cyc++;
      if (wr_req_valid_o && wr_req_ready_i) begin
        wr_addr_log.push_back(wr_req_addr_o);
        wr_len_log.push_back(wr_req_len_o);
        wr_due.push_back(cyc + wr_lat);
      end
    end
  end

  task automatic clr_logs();
    rd_addr_log.delete(); rd_sel_log.delete(); rd_len_log.delete();
    arr_clr_log.delete(); wr_addr_log.delete(); wr_len_log.delete();
    rd_vld_cyc = 0; wr_vld_cyc = 0;
  endtask

  task automatic pulse_start(input logic [7:0] w, input logic [31:0] a, b, c);
    @(posedge clk); #1;
    mat_width_i = w; a_addr_i = a; b_addr_i = b; c_addr_i = c;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit expired = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        expired = 1'b0;
        break;
      end
    end
    chk({tag, "_timeout"}, expired, 1'b0);
  endtask

  task automatic run_legal(input string tag, input logic [7:0] w, input logic [31:0] a, b, c);
    clr_logs();
    pulse_start(w, a, b, c);
    @(negedge clk);
    chk({tag, "_start_flags"}, {busy_o, done_o, err_o}, 3'b100);
    wait_idle(tag);
    chk({tag, "_end_flags"}, {busy_o, done_o, err_o}, 3'b010);
  endtask

  task automatic check_one_chunk(input string tag, input logic [31:0] a, b, c);
    chk({tag, "_rd_n"}, rd_addr_log.size(), 2);
    chk({tag, "_rdA"}, {rd_sel_log[0], rd_len_log[0], rd_addr_log[0]}, {1'b0, 8'd15, a});
    chk({tag, "_rdB"}, {rd_sel_log[1], rd_len_log[1], rd_addr_log[1]}, {1'b1, 8'd15, b});
    chk({tag, "_arr"}, {arr_clr_log.size(), arr_clr_log[0]}, {32'd1, 1'b1});
    chk({tag, "_wr"}, {wr_addr_log.size(), wr_len_log[0], wr_addr_log[0]}, {32'd1, 8'd15, c});
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy_o, done_o, err_o, rd_req_valid_o, rd_req_sel_o,
                        arr_start_o, arr_clr_o, wr_req_valid_o}, 8'h00);
    chk({tag, "_bus"}, {rd_req_addr_o, wr_req_addr_o}, 64'h0);
    chk({tag, "_len"}, {rd_req_len_o, wr_req_len_o}, 16'h0);
`ifdef MME_PERF_CNT_EN
    chk({tag, "_perf"}, cycle_cnt_o, 32'h0);
`endif
  endtask

  initial begin
    logic [7:0] bad_w[3];
    bad_w[0] = 8'd6; bad_w[1] = 8'd0; bad_w[2] = 8'd68;

    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_legal("w4", 8'd4, 32'h0, 32'h1000, 32'h2000);
    check_one_chunk("w4", 32'h0, 32'h1000, 32'h2000);

    run_legal("w16", 8'd16, 32'h0, 32'h1000, 32'h2000);
    chk("w16_rd_n", rd_addr_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w16_rdA%0d", i), {rd_sel_log[2*i], rd_addr_log[2*i]}, {1'b0, 32'(i * 'h40)});
      chk($sformatf("w16_rdB%0d", i), {rd_sel_log[2*i+1], rd_addr_log[2*i+1]},
          {1'b1, 32'h1000 + 32'(i * 'h40)});
    end
    chk("w16_clr", {arr_clr_log.size(), arr_clr_log[0], arr_clr_log[1], arr_clr_log[2], arr_clr_log[3]},
        {32'd4, 4'b1000});
    chk("w16_wr_n", wr_addr_log.size(), 1);

    // address wrap at the top of the 32-bit space
    run_legal("wrap", 8'd8, 32'hFFFF_FFC0, 32'hFFFF_FF80, 32'h10);
    chk("wrap_rd", {rd_addr_log[0], rd_addr_log[1], rd_addr_log[2], rd_addr_log[3]},
        {32'hFFFF_FFC0, 32'hFFFF_FF80, 32'h0, 32'hFFFF_FFC0});

    run_legal("w64", 8'd64, 32'h8000, 32'h9000, 32'hA000);
    chk("w64_counts", {rd_addr_log.size(), arr_clr_log.size(), wr_addr_log.size()}, {32'd32, 32'd16, 32'd1});
    chk("w64_last_rdB", rd_addr_log[31], 32'h93C0);

    foreach (bad_w[k]) begin
      clr_logs();
      pulse_start(bad_w[k], 32'h0, 32'h1000, 32'h2000);
      @(negedge clk);
      chk($sformatf("bad%0d_flags", bad_w[k]), {busy_o, done_o, err_o}, 3'b011);
      repeat (10) @(negedge clk);
      chk($sformatf("bad%0d_noreq", bad_w[k]), {rd_vld_cyc, wr_vld_cyc, arr_clr_log.size()}, 96'h0);
      chk($sformatf("bad%0d_sticky", bad_w[k]), {done_o, err_o}, 2'b11);
    end

    // backpressure on both reads; A's completion lands while B is stalled
    rd_stall = 5; rd_lat = 2;
    run_legal("stall", 8'd4, 32'h300, 32'h4000, 32'h5000);
    check_one_chunk("stall", 32'h300, 32'h4000, 32'h5000);
    chk("stall_vld_cycles", rd_vld_cyc, 12);
    rd_stall = 0; rd_lat = 1;

    // start during COMP_WAIT must be ignored
    arr_lat = 6;
    clr_logs();
    pulse_start(8'd4, 32'h100, 32'h200, 32'h300);
    for (int i = 0; i < 200 && arr_clr_log.size() == 0; i++) @(negedge clk);
    chk("ign_saw_comp", arr_clr_log.size(), 1);
    @(posedge clk); #1;
    mat_width_i = 8'd8; a_addr_i = 32'hAAA0; b_addr_i = 32'hBBB0; c_addr_i = 32'hCCC0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle("ign");
    chk("ign_flags", {busy_o, done_o, err_o}, 3'b010);
    check_one_chunk("ign", 32'h100, 32'h200, 32'h300);
    arr_lat = 1;

    // reset while RD_B is stalled
    rd_stall = 5;
    clr_logs();
    pulse_start(8'd4, 32'h600, 32'h700, 32'h800);
    for (int i = 0; i < 200 && !(rd_req_valid_o && rd_req_sel_o); i++) @(negedge clk);
    chk("rst_saw_rdB", {rd_req_valid_o, rd_req_sel_o}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    repeat (3) @(negedge clk);
    check_reset_outs("rst_hold");
    rd_due.delete(); arr_due.delete(); wr_due.delete();
    rd_stall = 0; stall_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_legal("after_rst", 8'd4, 32'h40, 32'h1040, 32'h2040);
    check_one_chunk("after_rst", 32'h40, 32'h1040, 32'h2040);

`ifdef MME_PERF_CNT_EN
    rd_lat = 3; arr_lat = 3; wr_lat = 3;
    run_legal("perf", 8'd4, 32'h0, 32'h1000, 32'h2000);
    chk("perf_cnt", cycle_cnt_o, 32'd13);
    repeat (5) @(negedge clk);
    chk("perf_hold", cycle_cnt_o, 32'd13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
